// File: rtl/text_seq_pkg.sv
// Shared constants, FSM state encoding and helpers for the text sequencer.
package text_seq_pkg;

  localparam int unsigned SCR_W      = 640;
  localparam int unsigned SCR_H      = 480;
  localparam int unsigned GLYPH_ROWS = 10;

  localparam logic [5:0] CODE_BLANK   = 6'd38;
  localparam logic [5:0] CODE_NEWLINE = 6'd62;
  localparam logic [5:0] CODE_HOME    = 6'd63;

  typedef logic [1:0] state_t;
  localparam state_t StIdle    = 2'd0;
  localparam state_t StFetch   = 2'd1;
  localparam state_t StReq     = 2'd2;
  localparam state_t StAdvance = 2'd3;

  // What the ADVANCE state has to do with the cursor for the popped code.
  typedef enum logic [1:0] {
    KindGlyph,
    KindNewline,
    KindHome,
    KindDrop
  } kind_t;

  // Codes 39-61 have no glyph and render as blank.
  function automatic logic [5:0] rom_code(input logic [5:0] code);
    return (code > CODE_BLANK) ? CODE_BLANK : code;
  endfunction

endpackage

// File: rtl/text_char_fifo.sv
// Synchronous character FIFO with registered full/empty flags.
module text_char_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // Flags are registered, so a pop never makes room for a push in the same cycle.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;
  assign count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Storage array; contents are don't-care while empty so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CntW'(Depth));
      empty_q <= (count_d == '0);
    end
  end

endmodule

// File: rtl/text_sequencer.sv
// Text sequencer: buffers letter codes, tracks the cursor and issues one VRAM
// line read-modify-write per glyph row. Define TEXT_SEQ_WRAP_EN to wrap glyphs
// past column 79 onto the next row; otherwise the cursor parks at the last
// column and further glyphs are discarded until a newline or home.
module text_sequencer
  import text_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CELL_W     = 8,
  parameter int unsigned CELL_H     = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  output logic [5:0] glyph_code,
  output logic [3:0] glyph_row,
  output logic [9:0] x_pos,
  output logic [8:0] y_pos,
  output logic [8:0] line_addr,
  output logic       vram_req,
  input  logic       vram_gnt,
  output logic       vram_we,
  output logic       busy
);

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [5:0]  fifo_rdata;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [5:0]  code_q, code_d;
  logic [3:0]  row_q, row_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        ovf_q, ovf_d;
  logic [10:0] x_inc;
  logic [9:0]  y_inc;
  logic [8:0]  y_next_row;

  text_char_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (6)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (char_valid),
    .wdata_i (char_code),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Widened sums so the screen-edge comparisons cannot overflow.
  assign x_inc      = {1'b0, x_q} + 11'(CELL_W);
  assign y_inc      = {1'b0, y_q} + 10'(CELL_H);
  assign y_next_row = (y_inc >= 10'(SCR_H)) ? '0 : y_inc[8:0];

  // Next-state logic: pop, per-row fetch/request sequencing and cursor update.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    code_d   = code_q;
    row_d    = row_q;
    x_d      = x_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    fifo_pop = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StAdvance;
          if (fifo_rdata == CODE_NEWLINE) begin
            kind_d = KindNewline;
          end else if (fifo_rdata == CODE_HOME) begin
            kind_d = KindHome;
          end else if (ovf_q) begin
            kind_d = KindDrop;
          end else begin
            kind_d  = KindGlyph;
            code_d  = rom_code(fifo_rdata);
            row_d   = '0;
            state_d = StFetch;
          end
        end
      end
      StFetch: state_d = StReq;
      StReq: begin
        if (vram_gnt) begin
          if (row_q == 4'(GLYPH_ROWS - 1)) begin
            state_d = StAdvance;
          end else begin
            row_d   = row_q + 4'd1;
            state_d = StFetch;
          end
        end
      end
      StAdvance: begin
        state_d = StIdle;
        unique case (kind_q)
          KindGlyph: begin
            if (x_inc >= 11'(SCR_W)) begin
`ifdef TEXT_SEQ_WRAP_EN
              x_d = '0;
              y_d = y_next_row;
`else
              ovf_d = 1'b1;
`endif
            end else begin
              x_d = x_inc[9:0];
            end
          end
          KindNewline: begin
            x_d   = '0;
            y_d   = y_next_row;
            ovf_d = 1'b0;
          end
          KindHome: begin
            x_d   = '0;
            y_d   = '0;
            ovf_d = 1'b0;
          end
          KindDrop: ;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and cursor state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      kind_q  <= KindGlyph;
      code_q  <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      code_q  <= code_d;
      row_q   <= row_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
    end
  end

  assign char_ready = ~fifo_full;
  assign glyph_code = code_q;
  assign glyph_row  = row_q;
  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign line_addr  = y_q + {5'd0, row_q};
  assign vram_req   = (state_q == StReq);
  assign vram_we    = vram_req & vram_gnt;
  assign busy       = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_text_sequencer.sv
// Self-checking bench for text_sequencer: directed table, corner sequences and
// a randomized run against a per-character reference model.
module tb_text_sequencer;

  logic       clk, rst_n;
  logic       char_valid, char_ready;
  logic [5:0] char_code, glyph_code;
  logic [3:0] glyph_row;
  logic [9:0] x_pos;
  logic [8:0] y_pos, line_addr;
  logic       vram_req, vram_gnt, vram_we, busy;

  int checks   = 0;
  int failures = 0;

  text_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_ready (char_ready),
    .glyph_code (glyph_code),
    .glyph_row  (glyph_row),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .line_addr  (line_addr),
    .vram_req   (vram_req),
    .vram_gnt   (vram_gnt),
    .vram_we    (vram_we),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One character: code, grant delay per row (0 = grant tied high), expected
  // glyph code, first line address, write count, x during writes, final x/y,
  // and cycles from pop until busy falls.
  typedef struct {
    logic [5:0] code;
    int         dly;
    logic [5:0] glyph;
    int         base;
    int         nw;
    int         wx;
    int         x;
    int         y;
    int         cyc;
  } vec_t;

  typedef struct {
    int addr;
    int glyph;
    int x;
    int y;
  } wr_t;

  // Reference model state for the randomized phase.
  int  mx, my;
  bit  movf;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_char(input int code);
    int g;
    if (code == 62) begin
      mx = 0; my = (my + 12) % 480; movf = 0;
    end else if (code == 63) begin
      mx = 0; my = 0; movf = 0;
    end else if (!movf) begin
      g = (code > 38) ? 38 : code;
      for (int r = 0; r < 10; r++) exp_q.push_back('{my + r, g, mx, my});
      if (mx + 8 == 640) begin
`ifdef TEXT_SEQ_WRAP_EN
        mx = 0; my = (my + 12) % 480;
`else
        movf = 1;
`endif
      end else begin
        mx = mx + 8;
      end
    end
  endfunction

  function automatic logic [5:0] rand_code();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70)      return 6'($urandom_range(0, 38));
    else if (r < 80) return 6'($urandom_range(39, 61));
    else if (r < 92) return 6'd62;
    else             return 6'd63;
  endfunction

  task automatic check_write();
    wr_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL rnd_write: unexpected write at line %0d, required none", line_addr);
    end else begin
      e = exp_q.pop_front();
      check("rnd_line_addr", line_addr, e.addr);
      check("rnd_glyph_code", glyph_code, e.glyph);
      check("rnd_x_pos", x_pos, e.x);
      check("rnd_y_pos", y_pos, e.y);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_code  = '0;
    vram_gnt   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Push one code into an idle DUT and follow it until busy falls.
  task automatic run_char(input vec_t v);
    int          n, nw, nreq, wait_cnt;
    logic [37:0] snap, cur;
    n = 0; nw = 0; nreq = 0; wait_cnt = 0; snap = '0;
    @(posedge clk); #1;
    char_valid = 1'b1;
    char_code  = v.code;
    vram_gnt   = (v.dly == 0);
    @(posedge clk); #1;
    char_valid = 1'b0;
    while (n < 300) begin
      if (v.dly == 0) begin
        vram_gnt = 1'b1;
      end else if (vram_req) begin
        wait_cnt++;
        vram_gnt = (wait_cnt > v.dly);
      end else begin
        wait_cnt = 0;
        vram_gnt = 1'b0;
      end
      @(negedge clk);
      if (!busy) break;
      if (vram_req) begin
        nreq++;
        cur = {line_addr, glyph_code, glyph_row, x_pos, y_pos};
        if (v.dly != 0) begin
          if (wait_cnt == 1) snap = cur;
          else check("hold_during_req", cur, snap);
        end
      end
      if (vram_we) begin
        check("write_line_addr", line_addr, v.base + nw);
        check("write_glyph_code", glyph_code, v.glyph);
        check("write_glyph_row", glyph_row, nw);
        check("write_x_pos", x_pos, v.wx);
        check("write_cycle", n, 2 + nw * (2 + v.dly) + v.dly);
        nw++;
      end
      n++;
      @(posedge clk); #1;
    end
    vram_gnt = 1'b0;
    check("char_cycles", n, v.cyc);
    check("char_writes", nw, v.nw);
    check("char_reqs", nreq, v.nw * (1 + v.dly));
    check("char_x_pos", x_pos, v.x);
    check("char_y_pos", y_pos, v.y);
  endtask

  vec_t tbl[10];

  initial begin
    int acc, ex, ey, drained;
    vec_t v;

    rst_n = 1'b1;
    #2;
    do_reset();

    // Reset values; grant high to confirm it is ignored outside REQ.
    vram_gnt = 1'b1;
    @(negedge clk);
    check("rst_char_ready", char_ready, 1);
    check("rst_vram_req", vram_req, 0);
    check("rst_vram_we", vram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_glyph_row", glyph_row, 0);
    check("rst_glyph_code", glyph_code, 0);
    check("rst_x_pos", x_pos, 0);
    check("rst_y_pos", y_pos, 0);
    check("rst_line_addr", line_addr, 0);
    vram_gnt = 1'b0;

    tbl[0] = '{6'd5,  0, 6'd5,  0,  10, 0,  8,  0,  22};
    tbl[1] = '{6'd62, 0, 6'd0,  0,  0,  0,  0,  12, 2};
    tbl[2] = '{6'd62, 0, 6'd0,  0,  0,  0,  0,  24, 2};
    tbl[3] = '{6'd5,  3, 6'd5,  24, 10, 0,  8,  24, 52};
    tbl[4] = '{6'd50, 1, 6'd38, 24, 10, 8,  16, 24, 32};
    tbl[5] = '{6'd62, 0, 6'd0,  0,  0,  0,  0,  36, 2};
    tbl[6] = '{6'd63, 0, 6'd0,  0,  0,  0,  0,  0,  2};
    tbl[7] = '{6'd37, 0, 6'd37, 0,  10, 0,  8,  0,  22};
    tbl[8] = '{6'd38, 2, 6'd38, 0,  10, 8,  16, 0,  42};
    tbl[9] = '{6'd61, 0, 6'd38, 0,  10, 16, 24, 0,  22};
    for (int i = 0; i < 10; i++) run_char(tbl[i]);

    // Vertical wrap: bottom row glyph reaches line 477, next newline returns to 0.
    run_char('{6'd63, 0, 6'd0, 0, 0, 0, 0, 0, 2});
    for (int i = 0; i < 39; i++) run_char('{6'd62, 0, 6'd0, 0, 0, 0, 0, 12 * (i + 1), 2});
    run_char('{6'd3, 0, 6'd3, 468, 10, 0, 8, 468, 22});
    run_char('{6'd62, 0, 6'd0, 0, 0, 0, 0, 0, 2});

    // Fill one text row, then the 81st glyph.
    for (int i = 0; i < 79; i++) begin
      v = '{6'(i % 38), 0, 6'(i % 38), 0, 10, 8 * i, 8 * (i + 1), 0, 22};
      run_char(v);
    end
`ifdef TEXT_SEQ_WRAP_EN
    ex = 0;   ey = 12;
`else
    ex = 632; ey = 0;
`endif
    run_char('{6'd4, 0, 6'd4, 0, 10, 632, ex, ey, 22});
`ifdef TEXT_SEQ_WRAP_EN
    run_char('{6'd9,  0, 6'd9, 12, 10, 0, 8, 12, 22});
    run_char('{6'd62, 0, 6'd0, 0,  0,  0, 0, 24, 2});
    run_char('{6'd2,  0, 6'd2, 24, 10, 0, 8, 24, 22});
`else
    run_char('{6'd9,  0, 6'd9, 0,  0,  0, 632, 0, 2});
    run_char('{6'd62, 0, 6'd0, 0,  0,  0, 0,  12, 2});
    run_char('{6'd2,  0, 6'd2, 12, 10, 0, 8,  12, 22});
`endif

    // Burst with grant withheld: 8 queued plus 1 popped, then reset mid-REQ.
    vram_gnt = 1'b0;
    acc = 0;
    @(posedge clk); #1;
    char_valid = 1'b1;
    char_code  = 6'd7;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (char_ready) acc++;
      @(posedge clk); #1;
    end
    char_valid = 1'b0;
    check("burst_accepted", acc, 9);
    check("burst_char_ready", char_ready, 0);
    check("burst_vram_req", vram_req, 1);
    #2;
    rst_n    = 1'b0;
    vram_gnt = 1'b1;
    #1;
    check("async_rst_vram_req", vram_req, 0);
    check("async_rst_vram_we", vram_we, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_char_ready", char_ready, 1);
    check("async_rst_x_pos", x_pos, 0);
    check("async_rst_y_pos", y_pos, 0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    vram_gnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_vram_req", vram_req, 0);

    // Randomized traffic and grant against the reference model.
    do_reset();
    mx = 0; my = 0; movf = 0;
    exp_q.delete();
    for (int c = 0; c < 2500; c++) begin
      vram_gnt   = ($urandom_range(0, 1) == 1);
      char_valid = ($urandom_range(0, 3) == 0);
      char_code  = rand_code();
      @(negedge clk);
      if (char_valid && char_ready) model_char(int'(char_code));
      if (vram_we) check_write();
      @(posedge clk); #1;
    end
    char_valid = 1'b0;
    drained = 0;
    for (int c = 0; c < 4000 && drained == 0; c++) begin
      vram_gnt = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (vram_we) check_write();
      if (!busy) drained = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("rnd_drained", busy, 0);
    check("rnd_pending_writes", exp_q.size(), 0);
    check("rnd_final_x", x_pos, mx);
    check("rnd_final_y", y_pos, my);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
